spi_miso_deser: RTL

- Receive-side companion to the SPI master. Watches the master's sclk, cs and the sensor's miso, and deserializes MSB-first bytes.
- Drops the command/address bytes at the start of each read frame. Buffers payload bytes (e.g. XDATA from a 0x0B 0x08 read) in a small FWFT FIFO with a valid/ready interface to downstream logic.
- Runs on the 100 MHz system clock. sclk and cs are treated as data, sampled and edge-detected.

---
 rtl/spi_rx_pkg.sv | 20 ++
 rtl/spi_rx_fifo.sv | 81 ++++++++
 rtl/spi_miso_deser.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: types and constants shared by the SPI MISO deserializer.
//   frame_state_e - frame FSM states (IDLE: cs high, ACTIVE: cs low)
//   SPI_CMD_*     - sensor command opcodes for the frames being watched
//   lvl_w()       - width of a FIFO occupancy count for a given depth
package spi_rx_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } frame_state_e;

  localparam logic [7:0] SPI_CMD_READ  = 8'h0B;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h0A;

  // Occupancy runs 0..depth inclusive, so one bit more than the pointer.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: first-word-fall-through byte FIFO with registered head.
//   clk, rst          - system clock, async active-high reset
//   push, push_data   - write request and byte
//   pop_req           - downstream ready; pops only while head_valid
//   head_data/valid   - registered head entry and its valid flag
//   full, empty       - occupancy flags
//   level             - current occupancy
//   drop              - one-cycle pulse when a push is lost to a full FIFO
// DEPTH must be a power of two (pointers wrap by natural overflow).
module spi_rx_fifo import spi_rx_pkg::*; #(
  parameter  int DEPTH = 4,
  localparam int LW    = lvl_w(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop_req,
  output logic [7:0]    head_data,
  output logic          head_valid,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          drop
);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d, lvl_after_pop;
  logic [7:0]    head_data_q, head_data_d;
  logic          head_valid_q, head_valid_d;
  logic          pop, accept;

  always_comb begin
    full     = (level_q == LW'(DEPTH));
    empty    = (level_q == '0);
    pop      = pop_req & head_valid_q & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    accept   = push & (~full | pop);
    drop     = push & full & ~pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(accept) - LW'(pop);
    // Head register looks only at entries already stored, so a fresh push
    // shows up at the output one cycle after it lands.
    lvl_after_pop = level_q - LW'(pop);
    head_valid_d  = (lvl_after_pop != '0);
    head_data_d   = head_valid_d ? mem_q[rd_ptr_d] : head_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      head_data_q  <= '0;
      head_valid_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      head_data_q  <= head_data_d;
      head_valid_q <= head_valid_d;
    end
  end

  assign head_data  = head_data_q;
  assign head_valid = head_valid_q;
  assign level      = level_q;

endmodule

// File: rtl/spi_miso_deser.sv
// spi_miso_deser: passive SPI mode-0 receive deserializer.
//   clk, rst      - 100 MHz system clock, async active-high reset
//   sclk, cs, miso- SPI pins, oversampled as data
//   rx_en         - bytes are pushed only while high
//   rx_data/valid/ready, fifo_level - FWFT payload FIFO interface
//   frame_done    - pulse when a frame ends (cs rises)
//   frag_err      - pulse when a frame ends mid-byte
//   overflow      - sticky, a payload byte was lost to a full FIFO
// Optional: define SPI_RX_WORD_EN to add word_data/word_valid, pairing
// payload bytes little-endian into 16-bit words.
module spi_miso_deser import spi_rx_pkg::*; #(
  parameter  int SKIP_BYTES      = 2,
  parameter  int FIFO_DEPTH      = 4,
  parameter  int MAX_FRAME_BYTES = 7,
  localparam int LW              = lvl_w(FIFO_DEPTH),
  localparam int BW              = $clog2(MAX_FRAME_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          cs,
  input  logic          miso,
  input  logic          rx_en,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [LW-1:0] fifo_level,
  output logic          frame_done,
  output logic          frag_err,
`ifdef SPI_RX_WORD_EN
  output logic [15:0]   word_data,
  output logic          word_valid,
`endif
  output logic          overflow
);

  logic         sclk_q1, sclk_q2, cs_q1, cs_q2, miso_q1;
  logic         smp_vld_q, armed_q, armed_d;
  frame_state_e state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic         frame_done_q, frame_done_d, frag_err_q, frag_err_d;
  logic         overflow_q, overflow_d;
  logic         rise, cs_fall, cs_rise, start, push, fifo_drop;
  logic         fifo_full, fifo_empty;

  always_comb begin
    rise    = sclk_q1 & ~sclk_q2;
    // cs held low across reset release must not look like a new frame, so
    // a fall only counts once cs has really been sampled high.
    cs_fall = ~cs_q1 & cs_q2 & armed_q;
    cs_rise = cs_q1 & ~cs_q2;
    armed_d = armed_q | (cs_q1 & smp_vld_q);

    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    frame_done_d = 1'b0;
    frag_err_d   = 1'b0;
    push         = 1'b0;
    start        = 1'b0;

    case (state_q)
      IDLE: begin
        // A coincident sclk rise is dropped: the frame starts clean.
        if (cs_fall) begin
          state_d    = ACTIVE;
          start      = 1'b1;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          shift_d    = '0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          frag_err_d   = (bit_cnt_q != 3'd0);
        end else if (rise) begin
          shift_d   = {shift_q[6:0], miso_q1};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (int'(byte_cnt_q) < MAX_FRAME_BYTES) byte_cnt_d = byte_cnt_q + BW'(1);
            push = rx_en & (int'(byte_cnt_q) >= SKIP_BYTES);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    overflow_d = overflow_q | fifo_drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q1      <= 1'b0;
      sclk_q2      <= 1'b0;
      cs_q1        <= 1'b1;
      cs_q2        <= 1'b1;
      miso_q1      <= 1'b0;
      smp_vld_q    <= 1'b0;
      armed_q      <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      frame_done_q <= 1'b0;
      frag_err_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      sclk_q1      <= sclk;
      sclk_q2      <= sclk_q1;
      cs_q1        <= cs;
      cs_q2        <= cs_q1;
      miso_q1      <= miso;
      smp_vld_q    <= 1'b1;
      armed_q      <= armed_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      frame_done_q <= frame_done_d;
      frag_err_q   <= frag_err_d;
      overflow_q   <= overflow_d;
    end
  end

  spi_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_d),
    .pop_req   (rx_ready),
    .head_data (rx_data),
    .head_valid(rx_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .drop      (fifo_drop)
  );

  assign frame_done = frame_done_q;
  assign frag_err   = frag_err_q;
  assign overflow   = overflow_q;

`ifdef SPI_RX_WORD_EN
  // Pairing follows push requests, so a byte dropped by a full FIFO still
  // keeps the word phase aligned with the sensor's byte stream.
  logic        phase_q, phase_d, word_valid_q, word_valid_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] word_q, word_d;

  always_comb begin
    phase_d      = phase_q;
    lo_d         = lo_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (start) begin
      phase_d = 1'b0;
    end else if (push) begin
      if (!phase_q) begin
        lo_d    = shift_d;
        phase_d = 1'b1;
      end else begin
        word_d       = {shift_d, lo_q};
        word_valid_d = 1'b1;
        phase_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q      <= 1'b0;
      lo_q         <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      lo_q         <= lo_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_data  = word_q;
  assign word_valid = word_valid_q;
`endif

endmodule
